// File: rtl/cart_discrete.sv
// Discrete-logic NES mapper (NROM / CNROM / UNROM / GxROM) with a small write-commit FSM.
// Define MAPPER_BUS_CONFLICT_EN to AND written data with the ROM byte at the write address.
module cart_discrete #(
  parameter int MODE          = 1,
  parameter int PRG_BANK_BITS = 3,
  parameter int CHR_BANK_BITS = 2,
  parameter int MIRROR_V      = 0,
  parameter int CHR_RAM       = 0,
  parameter int ROM_LATENCY   = 1
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       prg_nce_in,
  input  logic [14:0]                prg_a_in,
  input  logic                       prg_r_nw_in,
  input  logic [7:0]                 prg_d_in,
  output logic [7:0]                 prg_d_out,
  input  logic [13:0]                chr_a_in,
  input  logic                       chr_r_nw_in,
  input  logic [7:0]                 chr_d_in,
  output logic [7:0]                 chr_d_out,
  output logic                       ciram_nce_out,
  output logic                       ciram_a10_out,
  output logic [PRG_BANK_BITS+13:0]  prg_mem_a_out,
  input  logic [7:0]                 prg_rom_d_in,
  output logic [CHR_BANK_BITS+12:0]  chr_mem_a_out,
  input  logic [7:0]                 chr_mem_d_in,
  output logic [7:0]                 chr_mem_d_out,
  output logic                       chr_ram_we_out,
  output logic                       busy_out
);

  // state  | meaning
  // IDLE   | waiting for a CPU write edge
  // FETCH  | ROM byte at the write address settling (bus-conflict build only)
  // COMMIT | decode the effective value into the bank registers

  localparam int P  = PRG_BANK_BITS;
  localparam int C  = CHR_BANK_BITS;
  localparam int PA = P + 14;

`ifdef MAPPER_BUS_CONFLICT_EN
  localparam bit CONFLICT = 1'b1;
`else
  localparam bit CONFLICT = 1'b0;
`endif

  localparam logic [1:0]   FETCH_LAST = 2'(ROM_LATENCY - 1);
  localparam logic [P-1:0] GX_MASK    = ~(P'(1) << (P - 1));

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic           wr_q, wr_d;
  logic [7:0]     wd_q, wd_d;
  logic [14:0]    wa_q, wa_d;
  logic [1:0]     cnt_q, cnt_d;
  logic [P-1:0]   prg_bank_q, prg_bank_d;
  logic [C-1:0]   chr_bank_q, chr_bank_d;
  logic           busy_q, busy_d;

  logic           wr;
  logic           wr_edge;
  logic [C-1:0]   chr_bank_eff;

  assign wr      = ~prg_nce_in & ~prg_r_nw_in;
  assign wr_edge = wr & ~wr_q;

  function automatic logic [PA-1:0] map_prg(input logic [14:0] a, input logic [P-1:0] bank);
    logic [PA-1:0] m;
    case (MODE)
      2:       m = a[14] ? {{P{1'b1}}, a[13:0]} : {bank, a[13:0]};
      3:       m = (PA'(bank) << 15) | PA'(a);
      default: m = PA'(a);
    endcase
    return m;
  endfunction

  always_comb begin
    state_d    = state_q;
    wr_d       = wr;
    wd_d       = wd_q;
    wa_d       = wa_q;
    cnt_d      = cnt_q;
    prg_bank_d = prg_bank_q;
    chr_bank_d = chr_bank_q;

    case (state_q)
      IDLE: begin
        if (wr_edge) begin
          wd_d  = prg_d_in;
          wa_d  = prg_a_in;
          cnt_d = FETCH_LAST;
          if (CONFLICT) state_d = FETCH;
          else          state_d = COMMIT;
        end
      end
      FETCH: begin
        // The ROM drives the bus too; the data bus ends up as the wired-AND of both.
        if (cnt_q == 2'd0) begin
          wd_d    = wd_q & prg_rom_d_in;
          state_d = COMMIT;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      COMMIT: begin
        state_d = IDLE;
        case (MODE)
          1: chr_bank_d = C'(wd_q);
          2: prg_bank_d = P'(wd_q);
          3: begin
            prg_bank_d = P'(wd_q[5:4]) & GX_MASK;
            chr_bank_d = C'(wd_q[1:0]);
          end
          default: ;
        endcase
      end
      default: state_d = IDLE;
    endcase

    // Busy also covers the first cycle in which the new bank is visible.
    busy_d = (state_d != IDLE) | (state_q != IDLE);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      wr_q       <= 1'b0;
      wd_q       <= '0;
      wa_q       <= '0;
      cnt_q      <= '0;
      prg_bank_q <= '0;
      chr_bank_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_q       <= wr_d;
      wd_q       <= wd_d;
      wa_q       <= wa_d;
      cnt_q      <= cnt_d;
      prg_bank_q <= prg_bank_d;
      chr_bank_q <= chr_bank_d;
      busy_q     <= busy_d;
    end
  end

  assign chr_bank_eff = (MODE == 1 || MODE == 3) ? chr_bank_q : '0;

  assign prg_mem_a_out  = (CONFLICT && state_q == FETCH) ? map_prg(wa_q, prg_bank_q)
                                                          : map_prg(prg_a_in, prg_bank_q);
  assign chr_mem_a_out  = {chr_bank_eff, chr_a_in[12:0]};
  assign prg_d_out      = (~prg_nce_in & prg_r_nw_in) ? prg_rom_d_in : 8'h00;
  assign chr_d_out      = chr_a_in[13] ? 8'h00 : chr_mem_d_in;
  assign ciram_nce_out  = ~chr_a_in[13];
  assign ciram_a10_out  = (MIRROR_V != 0) ? chr_a_in[10] : chr_a_in[11];
  assign chr_mem_d_out  = chr_d_in;
  assign chr_ram_we_out = (CHR_RAM != 0) & ~chr_a_in[13] & ~chr_r_nw_in;
  assign busy_out       = busy_q;

endmodule

// File: tb/tb_cart_discrete.sv
// Bench for cart_discrete: one instance per mapper mode sharing the buses, checked against
// an arithmetic bank model with directed cases followed by random writes and reads.
module tb_cart_discrete;

  localparam int RL = 2;
`ifdef MAPPER_BUS_CONFLICT_EN
  localparam bit CONF = 1'b1;
  localparam int LAT  = RL + 2;
`else
  localparam bit CONF = 1'b0;
  localparam int LAT  = 2;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        nce, rnw, crnw;
  logic [14:0] pa;
  logic [7:0]  pd, cd, rom, cmem;
  logic [13:0] ca;

  logic [7:0]  prg_do [4];
  logic [7:0]  chr_do [4];
  logic [7:0]  chr_mdo [4];
  logic        cnce [4];
  logic        ca10 [4];
  logic        we [4];
  logic        busy [4];
  logic [16:0] pma [4];
  logic [14:0] cma [4];

  int vectors = 0;
  int miscompares = 0;
  int m_prg [4];
  int m_chr [4];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    cart_discrete #(
      .MODE(g), .PRG_BANK_BITS(3), .CHR_BANK_BITS(2),
      .MIRROR_V(g % 2), .CHR_RAM(g % 2), .ROM_LATENCY(RL)
    ) u_dut (
      .clk_in(clk), .rst_in(rst),
      .prg_nce_in(nce), .prg_a_in(pa), .prg_r_nw_in(rnw), .prg_d_in(pd), .prg_d_out(prg_do[g]),
      .chr_a_in(ca), .chr_r_nw_in(crnw), .chr_d_in(cd), .chr_d_out(chr_do[g]),
      .ciram_nce_out(cnce[g]), .ciram_a10_out(ca10[g]),
      .prg_mem_a_out(pma[g]), .prg_rom_d_in(rom),
      .chr_mem_a_out(cma[g]), .chr_mem_d_in(cmem), .chr_mem_d_out(chr_mdo[g]),
      .chr_ram_we_out(we[g]), .busy_out(busy[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_prg(int m, int a);
    if (m == 2) return (a >= 16384) ? 7 * 16384 + a % 16384 : m_prg[2] * 16384 + a % 16384;
    if (m == 3) return m_prg[3] * 32768 + a;
    return a;
  endfunction

  function automatic int exp_chr(int m, int c);
    if (m == 1 || m == 3) return m_chr[m] * 8192 + c % 8192;
    return c % 8192;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 4; m++) begin
      m_prg[m] = 0;
      m_chr[m] = 0;
    end
  endtask

  task automatic model_write(input int v);
    m_chr[1] = v % 4;
    m_prg[2] = v % 8;
    m_prg[3] = (v / 16) % 4;
    m_chr[3] = v % 4;
  endtask

  task automatic cpu_write(input logic [14:0] a, input logic [7:0] d, input int hold);
    @(negedge clk);
    pa = a; pd = d; nce = 1'b0; rnw = 1'b0;
    repeat (hold) @(negedge clk);
    nce = 1'b1; rnw = 1'b1;
  endtask

  task automatic settle();
    repeat (LAT + 2) @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    model_reset();
  endtask

  task automatic check_all(input logic [14:0] a, input logic [13:0] c);
    int ai, ci;
    pa = a; ca = c; #1;
    ai = int'(a); ci = int'(c);
    for (int m = 0; m < 4; m++) begin
      check($sformatf("pma%0d", m), 32'(pma[m]), 32'(exp_prg(m, ai)));
      check($sformatf("cma%0d", m), 32'(cma[m]), 32'(exp_chr(m, ci)));
      check($sformatf("cnce%0d", m), 32'(cnce[m]), (ci >= 8192) ? 0 : 1);
      check($sformatf("ca10_%0d", m), 32'(ca10[m]), (m % 2 == 1) ? (ci / 1024) % 2 : (ci / 2048) % 2);
      check($sformatf("we%0d", m), 32'(we[m]), (m % 2 == 1 && ci < 8192 && crnw == 1'b0) ? 1 : 0);
      check($sformatf("prgdo%0d", m), 32'(prg_do[m]), (nce == 1'b0 && rnw == 1'b1) ? 32'(rom) : 0);
      check($sformatf("chrdo%0d", m), 32'(chr_do[m]), (ci >= 8192) ? 0 : 32'(cmem));
      check($sformatf("chrmdo%0d", m), 32'(chr_mdo[m]), 32'(cd));
    end
  endtask

  initial begin
    int cnt;
    int d, r;
    rst = 1'b1; nce = 1'b1; rnw = 1'b1; crnw = 1'b1;
    pa = '0; pd = '0; ca = '0; cd = '0; rom = 8'hFF; cmem = 8'h00;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // CNROM after reset, then $03 write with latency probe.
    for (int m = 0; m < 4; m++) check($sformatf("rst_busy%0d", m), 32'(busy[m]), 0);
    check_all(15'h0000, 14'h0005);
    check("cn_rst_0005", 32'(cma[1]), 32'h0005);
    cpu_write(15'h0000, 8'h03, 1);
    repeat (LAT - 2) @(negedge clk);
    ca = 14'h0005; #1;
    check("cn_lat_old", 32'(cma[1]), 32'h0005);
    @(negedge clk); #1;
    check("cn_lat_new", 32'(cma[1]), 32'h6005);
    model_write(3);
    settle();
    check_all(15'h4321, 14'h2c05);

    // UNROM $05, then reset returns to bank 0.
    cpu_write(15'h0000, 8'h05, 1);
    model_write(5);
    settle();
    check_all(15'h0010, 14'h0400);
    check("un_8010", 32'(pma[2]), 32'h14010);
    check_all(15'h4010, 14'h0800);
    check("un_c010", 32'(pma[2]), 32'h1C010);
    pulse_reset();
    check_all(15'h0010, 14'h1234);
    check("un_rst_8010", 32'(pma[2]), 32'h00010);

    // Long strobe: exactly one commit.
    cnt = 0;
    @(negedge clk);
    pa = 15'h0000; pd = 8'h02; nce = 1'b0; rnw = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy[2]) cnt++;
    end
    nce = 1'b1; rnw = 1'b1;
    for (int i = 0; i < LAT + 4; i++) begin
      @(negedge clk);
      if (busy[2]) cnt++;
    end
    check("hold_busy_cycles", 32'(cnt), 32'(LAT));
    model_write(2);
    check_all(15'h0010, 14'h0000);
    check("un_hold_8010", 32'(pma[2]), 32'h08010);

    // GxROM $31.
    cpu_write(15'h7FFF, 8'h31, 2);
    model_write(8'h31);
    settle();
    check_all(15'h0000, 14'h1FFF);
    check("gx_8000", 32'(pma[3]), 32'h18000);
    check("gx_1fff", 32'(cma[3]), 32'h3FFF);

    // Reset while the write is still in flight: no bank update.
    pulse_reset();
    cpu_write(15'h0000, 8'h03, 1);
    rst = 1'b1; #1;
    check("inflight_rst_busy", 32'(busy[1]), 0);
    @(negedge clk); rst = 1'b0;
    settle();
    check_all(15'h0000, 14'h0005);
    check("inflight_rst_chr", 32'(cma[1]), 32'h0005);

`ifdef MAPPER_BUS_CONFLICT_EN
    rom = 8'h01;
    cpu_write(15'h0000, 8'h03, 1);
    model_write(8'h03 & 8'h01);
    settle();
    check_all(15'h0000, 14'h0005);
    check("bc_chr1", 32'(cma[1]), 32'h2005);
    rom = 8'hFF;
    cpu_write(15'h0000, 8'h02, 1);
    @(negedge clk);
    pd = 8'h03; nce = 1'b0; rnw = 1'b0;
    @(negedge clk);
    nce = 1'b1; rnw = 1'b1;
    model_write(2);
    settle();
    check_all(15'h0000, 14'h0005);
    check("bc_drop_2nd", 32'(cma[1]), 32'h4005);
`endif

    // Random writes followed by random reads of both buses.
    for (int it = 0; it < 40; it++) begin
      d = int'($urandom_range(0, 255));
      r = int'($urandom_range(0, 255));
      rom = 8'(r);
      cpu_write(15'($urandom_range(0, 32767)), 8'(d), int'($urandom_range(1, 3)));
      model_write(CONF ? (d & r) : d);
      settle();
      for (int k = 0; k < 3; k++) begin
        rom  = 8'($urandom_range(0, 255));
        cmem = 8'($urandom_range(0, 255));
        cd   = 8'($urandom_range(0, 255));
        crnw = 1'($urandom_range(0, 1));
        nce  = 1'($urandom_range(0, 1));
        rnw  = 1'b1;
        check_all(15'($urandom_range(0, 32767)), 14'($urandom_range(0, 16383)));
      end
      nce = 1'b1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
